// File: rtl/assoc_cache.sv
`default_nettype none
// ----------------------------------------------------------------------------
// assoc_cache : write-back, write-allocate N-way set-associative cache, true LRU
// Rev 1.0
// ----------------------------------------------------------------------------
module assoc_cache #(
  parameter int SETS  = 4,
  parameter int WAYS  = 4,
  parameter int WORDS = 4
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Suspense,
  input  logic        Req,
  input  logic        WE,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  output logic        Hit,
  output logic [31:0] RD,
  output logic [31:0] MAddr,
  output logic        MRE,
  output logic        MWE,
  output logic [31:0] MWD,
  input  logic        MReady,
  input  logic [31:0] MRD
);

  localparam int WL  = $clog2(WAYS);
  localparam int CW  = $clog2(WORDS);
  localparam int IDX = $clog2(SETS);
  localparam int OFF = CW + 2;
  localparam int TAG = 32 - OFF - IDX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_FILL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WL-1:0] victim_q, victim_d;

  logic [31:0]                          data_q [SETS][WAYS][WORDS];
  logic [SETS-1:0][WAYS-1:0][TAG-1:0]   tag_q;
  logic [SETS-1:0][WAYS-1:0]            valid_q;
  logic [SETS-1:0][WAYS-1:0]            dirty_q;
  logic [SETS-1:0][WAYS-1:0][WL-1:0]    age_q;

  logic [TAG-1:0] tag;
  logic [IDX-1:0] idx;
  logic [CW-1:0]  word;
  logic           hit_any;
  logic [WL-1:0]  hit_way;
  logic [WL-1:0]  victim_sel;
  logic           start_fill;
  logic           wb_done;
  logic           fill_we;
  logic           fill_done;
  logic           unused_addr_bits;

  assign tag  = Addr[31:OFF+IDX];
  assign idx  = Addr[OFF+IDX-1:OFF];
  assign word = Addr[OFF-1:2];
  assign unused_addr_bits = ^Addr[1:0];

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit_any = 1'b1;
        hit_way = WL'(w);
      end
    end
  end

  // Oldest way is the fallback; descending scan lets the lowest invalid way win.
  always_comb begin
    victim_sel = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[idx][w] == WL'(WAYS - 1)) victim_sel = WL'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) victim_sel = WL'(w);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    victim_d   = victim_q;
    Hit        = 1'b0;
    RD         = '0;
    MAddr      = '0;
    MRE        = 1'b0;
    MWE        = 1'b0;
    MWD        = '0;
    start_fill = 1'b0;
    wb_done    = 1'b0;
    fill_we    = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        Hit = Req & hit_any;
        if (Hit && !WE) RD = data_q[idx][hit_way][word];
        if (Req && !hit_any) begin
          victim_d = victim_sel;
          cnt_d    = '0;
          if (dirty_q[idx][victim_sel]) begin
            state_d = S_WB;
          end else begin
            state_d    = S_FILL;
            start_fill = 1'b1;
          end
        end
      end
      S_WB: begin
        MWE   = 1'b1;
        MAddr = {tag_q[idx][victim_q], idx, cnt_q, 2'b00};
        MWD   = data_q[idx][victim_q][cnt_q];
        if (MReady) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WORDS - 1)) begin
            state_d = S_FILL;
            wb_done = 1'b1;
          end
        end
      end
      S_FILL: begin
        MRE   = 1'b1;
        MAddr = {tag, idx, cnt_q, 2'b00};
        if (MReady) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WORDS - 1)) begin
            state_d   = S_IDLE;
            fill_done = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The victim is marked invalid while it is being refilled so an aborted fill leaves no stale line.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      victim_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WL'(w);
        end
      end
    end else if (!Suspense) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      if (Hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WL'(w) == hit_way) begin
            age_q[idx][w] <= '0;
          end else if (age_q[idx][w] < age_q[idx][hit_way]) begin
            age_q[idx][w] <= age_q[idx][w] + WL'(1);
          end
        end
        if (WE) dirty_q[idx][hit_way] <= 1'b1;
      end
      if (start_fill) valid_q[idx][victim_sel] <= 1'b0;
      if (wb_done) begin
        dirty_q[idx][victim_q] <= 1'b0;
        valid_q[idx][victim_q] <= 1'b0;
      end
      if (fill_done) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!Suspense) begin
      if (Hit && WE) data_q[idx][hit_way][word] <= WD;
      if (fill_we) data_q[idx][victim_q][cnt_q] <= MRD;
      if (fill_done) tag_q[idx][victim_q] <= tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// Directed bench for assoc_cache; memory model returns each word equal to its address.
module tb_assoc_cache;

  logic        CLK, Reset, Suspense, Req, WE, MReady;
  logic [31:0] Addr, WD, MRD;
  logic        Hit, MRE, MWE;
  logic [31:0] RD, MAddr, MWD;

  int          vectors;
  int          miscompares;
  int          n_wb, n_fill, cyc;
  logic [31:0] wb_a [8];
  logic [31:0] wb_d [8];
  logic [31:0] fill_a [8];
  logic [31:0] rd_seen;
  logic        busy_at_hit;
  logic        overlap;

  assoc_cache #(.SETS(4), .WAYS(4), .WORDS(4)) dut (
    .CLK(CLK), .Reset(Reset), .Suspense(Suspense), .Req(Req), .WE(WE),
    .Addr(Addr), .WD(WD), .Hit(Hit), .RD(RD), .MAddr(MAddr), .MRE(MRE),
    .MWE(MWE), .MWD(MWD), .MReady(MReady), .MRD(MRD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Entered and left at posedge+1; services WB/FILL until Hit, recording traffic.
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d);
    Req = 1'b1; Addr = a; WE = w; WD = d;
    n_wb = 0; n_fill = 0; cyc = 0; overlap = 1'b0;
    #1;
    while (!Hit && cyc < 200) begin
      if (MRE && MWE) overlap = 1'b1;
      if (MWE && n_wb < 8) begin wb_a[n_wb] = MAddr; wb_d[n_wb] = MWD; n_wb++; end
      if (MRE && n_fill < 8) begin fill_a[n_fill] = MAddr; n_fill++; end
      MReady = MRE | MWE;
      MRD    = MAddr;
      @(posedge CLK); #1;
      MReady = 1'b0;
      #1;
      cyc++;
    end
    vectors++;
    if (Hit !== 1'b1) begin
      miscompares++;
      $display("FAIL access_hit addr=%h: Hit=%b required 1", a, Hit);
    end
    vectors++;
    if (overlap !== 1'b0) begin
      miscompares++;
      $display("FAIL mre_mwe_exclusive addr=%h: both high seen=%b required 0", a, overlap);
    end
    rd_seen     = RD;
    busy_at_hit = MRE | MWE;
    @(posedge CLK); #1;
    Req = 1'b0; WE = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Suspense = 1'b0; Req = 1'b0; WE = 1'b0;
    Addr = '0; WD = '0; MReady = 1'b0; MRD = '0;
    @(posedge CLK); #1;
    vectors++; if (Hit !== 1'b0)   begin miscompares++; $display("FAIL reset_hit got=%b exp=0", Hit); end
    vectors++; if (RD !== 32'h0)   begin miscompares++; $display("FAIL reset_rd got=%h exp=0", RD); end
    vectors++; if (MRE !== 1'b0)   begin miscompares++; $display("FAIL reset_mre got=%b exp=0", MRE); end
    vectors++; if (MWE !== 1'b0)   begin miscompares++; $display("FAIL reset_mwe got=%b exp=0", MWE); end
    vectors++; if (MAddr !== 32'h0) begin miscompares++; $display("FAIL reset_maddr got=%h exp=0", MAddr); end
    vectors++; if (MWD !== 32'h0)  begin miscompares++; $display("FAIL reset_mwd got=%h exp=0", MWD); end
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_cold_fill();
    access(32'h40, 1'b0, '0);
    vectors++; if (n_wb !== 0)   begin miscompares++; $display("FAIL cold_wb_count got=%0d exp=0", n_wb); end
    vectors++; if (n_fill !== 4) begin miscompares++; $display("FAIL cold_fill_count got=%0d exp=4", n_fill); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (fill_a[i] !== 32'h40 + 32'(4 * i)) begin
        miscompares++;
        $display("FAIL cold_fill_addr[%0d] got=%h exp=%h", i, fill_a[i], 32'h40 + 32'(4 * i));
      end
    end
    vectors++; if (rd_seen !== 32'h40) begin miscompares++; $display("FAIL cold_rd got=%h exp=00000040", rd_seen); end
  endtask

  task automatic test_store_hit();
    access(32'h44, 1'b1, 32'hDEADBEEF);
    vectors++; if (cyc !== 0) begin miscompares++; $display("FAIL store_hit_latency got=%0d exp=0", cyc); end
    vectors++; if (busy_at_hit !== 1'b0) begin miscompares++; $display("FAIL store_mem_idle got=%b exp=0", busy_at_hit); end
    vectors++; if (rd_seen !== 32'h0) begin miscompares++; $display("FAIL store_rd_zero got=%h exp=0", rd_seen); end
    access(32'h44, 1'b0, '0);
    vectors++; if (cyc !== 0) begin miscompares++; $display("FAIL load_after_store_latency got=%0d exp=0", cyc); end
    vectors++; if (rd_seen !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_after_store got=%h exp=deadbeef", rd_seen); end
  endtask

  task automatic test_lru_evict();
    access(32'h000, 1'b0, '0);
    vectors++; if (n_fill !== 4) begin miscompares++; $display("FAIL lru_fill_000 got=%0d exp=4", n_fill); end
    access(32'h040, 1'b0, '0);
    vectors++; if (cyc !== 0) begin miscompares++; $display("FAIL lru_hit_040 got=%0d exp=0", cyc); end
    access(32'h080, 1'b0, '0);
    access(32'h0C0, 1'b0, '0);
    vectors++; if (rd_seen !== 32'hC0) begin miscompares++; $display("FAIL lru_rd_0c0 got=%h exp=000000c0", rd_seen); end
    access(32'h000, 1'b0, '0);
    vectors++; if (cyc !== 0) begin miscompares++; $display("FAIL lru_rehit_000 got=%0d exp=0", cyc); end
    // Line 0x040 is oldest and dirty (0x44 stored earlier).
    access(32'h100, 1'b0, '0);
    vectors++; if (n_wb !== 4) begin miscompares++; $display("FAIL lru_evict_wb_count got=%0d exp=4", n_wb); end
    vectors++; if (wb_a[0] !== 32'h40) begin miscompares++; $display("FAIL lru_evict_wb_addr got=%h exp=00000040", wb_a[0]); end
    vectors++; if (wb_d[1] !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lru_evict_wb_data got=%h exp=deadbeef", wb_d[1]); end
    vectors++; if (fill_a[0] !== 32'h100) begin miscompares++; $display("FAIL lru_evict_fill_addr got=%h exp=00000100", fill_a[0]); end
    vectors++; if (rd_seen !== 32'h100) begin miscompares++; $display("FAIL lru_evict_rd got=%h exp=00000100", rd_seen); end
    access(32'h040, 1'b0, '0);
    vectors++; if (n_fill !== 4) begin miscompares++; $display("FAIL lru_040_remiss got=%0d exp=4", n_fill); end
    vectors++; if (n_wb !== 0) begin miscompares++; $display("FAIL lru_040_no_wb got=%0d exp=0", n_wb); end
    vectors++; if (rd_seen !== 32'h40) begin miscompares++; $display("FAIL lru_040_rd got=%h exp=00000040", rd_seen); end
  endtask

  task automatic test_dirty_evict();
    access(32'h000, 1'b1, 32'h1234);
    vectors++; if (cyc !== 0) begin miscompares++; $display("FAIL dirty_store_hit got=%0d exp=0", cyc); end
    access(32'h140, 1'b0, '0);
    access(32'h180, 1'b0, '0);
    access(32'h1C0, 1'b0, '0);
    vectors++; if (n_wb !== 0) begin miscompares++; $display("FAIL dirty_pre_wb got=%0d exp=0", n_wb); end
    access(32'h200, 1'b0, '0);
    vectors++; if (n_wb !== 4) begin miscompares++; $display("FAIL dirty_wb_count got=%0d exp=4", n_wb); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (wb_a[i] !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL dirty_wb_addr[%0d] got=%h exp=%h", i, wb_a[i], 32'(4 * i));
      end
    end
    vectors++; if (wb_d[0] !== 32'h1234) begin miscompares++; $display("FAIL dirty_wb_data0 got=%h exp=00001234", wb_d[0]); end
    vectors++; if (wb_d[3] !== 32'h0C) begin miscompares++; $display("FAIL dirty_wb_data3 got=%h exp=0000000c", wb_d[3]); end
    vectors++; if (n_fill !== 4) begin miscompares++; $display("FAIL dirty_fill_count got=%0d exp=4", n_fill); end
    vectors++; if (rd_seen !== 32'h200) begin miscompares++; $display("FAIL dirty_rd got=%h exp=00000200", rd_seen); end
  endtask

  task automatic test_reset_mid_fill();
    Req = 1'b1; Addr = 32'h10; WE = 1'b0; n_fill = 0; cyc = 0;
    #1;
    while (n_fill < 2 && cyc < 50) begin
      if (MRE) begin n_fill++; MReady = 1'b1; MRD = MAddr; end
      @(posedge CLK); #1;
      MReady = 1'b0;
      #1;
      cyc++;
    end
    vectors++; if (MAddr !== 32'h18) begin miscompares++; $display("FAIL midfill_maddr got=%h exp=00000018", MAddr); end
    Reset = 1'b1;
    #1;
    vectors++; if (MRE !== 1'b0) begin miscompares++; $display("FAIL abort_mre got=%b exp=0", MRE); end
    vectors++; if (Hit !== 1'b0) begin miscompares++; $display("FAIL abort_hit got=%b exp=0", Hit); end
    @(posedge CLK); #1;
    Reset = 1'b0;
    access(32'h10, 1'b0, '0);
    vectors++; if (n_fill !== 4) begin miscompares++; $display("FAIL refill_count got=%0d exp=4", n_fill); end
    vectors++; if (fill_a[0] !== 32'h10) begin miscompares++; $display("FAIL refill_addr0 got=%h exp=00000010", fill_a[0]); end
    vectors++; if (rd_seen !== 32'h10) begin miscompares++; $display("FAIL refill_rd got=%h exp=00000010", rd_seen); end
  endtask

  task automatic test_suspense();
    Req = 1'b1; Addr = 32'h20; WE = 1'b0; n_fill = 0; cyc = 0;
    #1;
    while (n_fill < 1 && cyc < 50) begin
      if (MRE) begin n_fill++; MReady = 1'b1; MRD = MAddr; end
      @(posedge CLK); #1;
      MReady = 1'b0;
      #1;
      cyc++;
    end
    Suspense = 1'b1;
    for (int i = 0; i < 3; i++) begin
      MReady = 1'b1; MRD = 32'hBAD0_0000;
      @(posedge CLK); #2;
      vectors++;
      if (MRE !== 1'b1 || MAddr !== 32'h24) begin
        miscompares++;
        $display("FAIL suspend_hold[%0d] got MRE=%b MAddr=%h exp MRE=1 MAddr=00000024", i, MRE, MAddr);
      end
    end
    MReady = 1'b0; Suspense = 1'b0;
    access(32'h20, 1'b0, '0);
    vectors++; if (n_fill !== 3) begin miscompares++; $display("FAIL resume_count got=%0d exp=3", n_fill); end
    vectors++; if (fill_a[0] !== 32'h24) begin miscompares++; $display("FAIL resume_addr got=%h exp=00000024", fill_a[0]); end
    vectors++; if (rd_seen !== 32'h20) begin miscompares++; $display("FAIL resume_rd got=%h exp=00000020", rd_seen); end
    access(32'h24, 1'b0, '0);
    vectors++; if (rd_seen !== 32'h24) begin miscompares++; $display("FAIL resume_word1 got=%h exp=00000024", rd_seen); end
    // A store hit while suspended must not reach the array.
    Suspense = 1'b1;
    access(32'h20, 1'b1, 32'h55);
    Suspense = 1'b0;
    access(32'h20, 1'b0, '0);
    vectors++; if (rd_seen !== 32'h20) begin miscompares++; $display("FAIL suspend_store_blocked got=%h exp=00000020", rd_seen); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_cold_fill();
    test_store_hit();
    test_lru_evict();
    test_dirty_evict();
    test_reset_mid_fill();
    test_suspense();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
